// File: rtl/bcd_conv_pkg.sv
// Shared types and constants for the sequential BCD-to-binary converter.
package bcd_conv_pkg;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  localparam logic [3:0] DIGIT_ADJ_THRESH = 4'd8;
  localparam logic [3:0] DIGIT_ADJ        = 4'd3;

  function automatic int bw_of(input int ndig);
    return 4 * ndig;
  endfunction

  function automatic int cnt_w_of(input int bw);
    return (bw > 1) ? $clog2(bw) : 1;
  endfunction

endpackage

// File: rtl/bcd_to_bin_seq_digit_adj.sv
// One BCD digit correction step of reverse double-dabble: if >= 8 subtract 3.
module bcd_digit_adj
  import bcd_conv_pkg::*;
(
  input  logic [3:0] d,
  output logic [3:0] q
);

  assign q = (d >= DIGIT_ADJ_THRESH) ? d - DIGIT_ADJ : d;

endmodule

// File: rtl/bcd_to_bin_seq.sv
// Sequential BCD-to-binary converter, one shift-right plus digit adjust per clock.
// Optional input digit validation enabled by defining BCD_DIGIT_CHECK_EN.
module bcd_to_bin_seq
  import bcd_conv_pkg::*;
#(
  parameter int NDIG = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [4*NDIG-1:0]   bcd_in,
  output logic                ready,
  output logic                busy,
  output logic                done,
  output logic [4*NDIG-1:0]   bin_out,
  output logic                err
);

  localparam int BW = bw_of(NDIG);
  localparam int CW = cnt_w_of(BW);
  localparam logic [CW-1:0] CNT_LAST = CW'(BW - 1);

  state_t            state, state_nx;
  logic [CW-1:0]     cnt;
  logic [2*BW-1:0]   sr, sr_shift, sr_next;
  logic              load;
  logic              bad;
  logic              last_shift;

  // Upper BW bits hold the BCD digits being drained; lower BW bits collect binary.
  assign sr_shift = {1'b0, sr[2*BW-1:1]};
  assign sr_next[BW-1:0] = sr_shift[BW-1:0];

  for (genvar g = 0; g < NDIG; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .d (sr_shift[BW + 4*g +: 4]),
      .q (sr_next [BW + 4*g +: 4])
    );
  end

`ifdef BCD_DIGIT_CHECK_EN
  function automatic logic has_bad_digit(input logic [BW-1:0] v);
    logic r;
    r = 1'b0;
    for (int i = 0; i < NDIG; i++) begin
      if (v[4*i +: 4] > 4'd9) r = 1'b1;
    end
    return r;
  endfunction

  assign bad = has_bad_digit(bcd_in);
`else
  assign bad = 1'b0;
`endif

  assign last_shift = (state == SHIFT) && (cnt == CNT_LAST);

  always_comb begin
    state_nx = state;
    load     = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          load     = 1'b1;
          state_nx = bad ? DONE : SHIFT;
        end
      end
      SHIFT: begin
        if (cnt == CNT_LAST) state_nx = DONE;
      end
      DONE: begin
        if (start) begin
          load     = 1'b1;
          state_nx = bad ? DONE : SHIFT;
        end else begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      bin_out <= '0;
    end else begin
      state <= state_nx;
      if (load)                cnt <= '0;
      else if (state == SHIFT) cnt <= cnt + 1'b1;
      if (last_shift)          bin_out <= sr_next[BW-1:0];
      else if (load && bad)    bin_out <= '0;
    end
  end

  // Datapath shift register carries no reset; it is always reloaded at accept.
  always_ff @(posedge clk) begin
    if (load)                sr <= {bcd_in, {BW{1'b0}}};
    else if (state == SHIFT) sr <= sr_next;
  end

`ifdef BCD_DIGIT_CHECK_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)               err <= 1'b0;
    else if (last_shift)   err <= 1'b0;
    else if (load && bad)  err <= 1'b1;
  end
`else
  assign err = 1'b0;
`endif

  assign ready = (state != SHIFT);
  assign busy  = (state == SHIFT);
  assign done  = (state == DONE);

endmodule

// File: tb/tb_bcd_to_bin_seq.sv
// Directed plus exhaustive-shuffled bench for bcd_to_bin_seq (NDIG=3) with a result scoreboard.
module tb_bcd_to_bin_seq;

  localparam int NDIG = 3;
  localparam int BW   = 12;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [BW-1:0] bcd_in;
  logic          ready, busy, done, err;
  logic [BW-1:0] bin_out;

  always #5 clk = ~clk;

  bcd_to_bin_seq #(.NDIG(NDIG)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .bcd_in  (bcd_in),
    .ready   (ready),
    .busy    (busy),
    .done    (done),
    .bin_out (bin_out),
    .err     (err)
  );

  typedef struct {
    logic [BW-1:0] bin;
    logic          err;
    bit            chk_bin;
  } exp_t;

  exp_t          sb[$];
  exp_t          mon_e;
  int            compared   = 0;
  int            mismatched = 0;
  int            ndone      = 0;
  logic          prev_done  = 1'b0;
  logic [BW-1:0] last_bin;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Result monitor: every done pulse consumes one scoreboard entry.
  always @(negedge clk) begin
    if (rst !== 1'b1) begin
      if (done === 1'b1) begin
        ndone++;
        check("done_width", {31'b0, prev_done}, 32'd0);
        if (sb.size() == 0) begin
          check("unexpected_done", 32'd1, 32'd0);
        end else begin
          mon_e = sb.pop_front();
          if (mon_e.chk_bin) check("bin_out", {20'b0, bin_out}, {20'b0, mon_e.bin});
          check("err", {31'b0, err}, {31'b0, mon_e.err});
        end
      end
      prev_done = done;
    end
  end

  function automatic logic [BW-1:0] to_bcd(input int v);
    return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  task automatic convert(input logic [BW-1:0] b, input logic [BW-1:0] exp_bin,
                         input logic exp_err, input bit chk_bin, input int exp_lat);
    exp_t e;
    int   n;
    @(negedge clk);
    start = 1'b1;
    bcd_in = b;
    e.bin = exp_bin;
    e.err = exp_err;
    e.chk_bin = chk_bin;
    sb.push_back(e);
    @(posedge clk);
    #1;
    start = 1'b0;
    bcd_in = 12'hBAD;
    n = 0;
    @(negedge clk);
    while (done !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("latency", n, exp_lat);
    last_bin = exp_bin;
  endtask

  initial begin
    int n;
    int k;
    int perm[1000];
    exp_t e;

    rst = 1'b1;
    start = 1'b0;
    bcd_in = '0;
    repeat (2) @(negedge clk);
    check("rst_ready", {31'b0, ready}, 32'd1);
    check("rst_busy",  {31'b0, busy},  32'd0);
    check("rst_done",  {31'b0, done},  32'd0);
    check("rst_bin",   {20'b0, bin_out}, 32'd0);
    check("rst_err",   {31'b0, err},   32'd0);
    rst = 1'b0;

    convert(12'h999, 12'd999, 1'b0, 1'b1, 12);
    convert(12'h255, 12'd255, 1'b0, 1'b1, 12);
    repeat (5) @(negedge clk);
    check("hold_255", {20'b0, bin_out}, 32'd255);
    convert(12'h000, 12'd0, 1'b0, 1'b1, 12);
    repeat (5) @(negedge clk);
    check("hold_0", {20'b0, bin_out}, 32'd0);

`ifdef BCD_DIGIT_CHECK_EN
    convert(12'h1A3, 12'd0, 1'b1, 1'b1, 0);
    repeat (3) @(negedge clk);
    check("hold_err", {31'b0, err}, 32'd1);
`else
    convert(12'h1A3, 12'd0, 1'b0, 1'b0, 12);
    repeat (3) @(negedge clk);
    check("hold_err", {31'b0, err}, 32'd0);
`endif

    // Start held high: three back-to-back conversions, a mid-SHIFT operand change is ignored.
    @(negedge clk);
    start = 1'b1;
    bcd_in = 12'h100;
    e.bin = 12'd100;
    e.err = 1'b0;
    e.chk_bin = 1'b1;
    repeat (3) sb.push_back(e);
    for (int i = 0; i < 3; i++) begin
      n = 0;
      do begin
        @(negedge clk);
        n++;
        if (i == 1 && n == 6) bcd_in = 12'h777;
        if (i == 1 && n == 7) bcd_in = 12'h100;
      end while (done !== 1'b1 && n < 40);
      check("b2b_period", n, 13);
    end
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("b2b_hold", {20'b0, bin_out}, 32'd100);

    // Reset in the middle of a conversion.
    @(negedge clk);
    start = 1'b1;
    bcd_in = 12'h999;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (6) @(negedge clk);
    check("mid_busy",  {31'b0, busy},  32'd1);
    check("mid_ready", {31'b0, ready}, 32'd0);
    rst = 1'b1;
    #1;
    check("arst_ready", {31'b0, ready}, 32'd1);
    check("arst_busy",  {31'b0, busy},  32'd0);
    check("arst_done",  {31'b0, done},  32'd0);
    check("arst_bin",   {20'b0, bin_out}, 32'd0);
    check("arst_err",   {31'b0, err},   32'd0);
    k = ndone;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (15) @(negedge clk);
    check("no_done_after_rst", ndone, k);
    sb.delete();

    convert(12'h042, 12'd42, 1'b0, 1'b1, 12);

    // Every valid 3-digit operand, in shuffled order.
    for (int i = 0; i < 1000; i++) perm[i] = i;
    for (int i = 999; i > 0; i--) begin
      int j;
      int t;
      j = int'($urandom_range(i, 0));
      t = perm[i];
      perm[i] = perm[j];
      perm[j] = t;
    end
    for (int i = 0; i < 1000; i++) begin
      convert(to_bcd(perm[i]), 12'(perm[i]), 1'b0, 1'b1, 12);
    end

    repeat (3) @(negedge clk);
    check("sb_empty", sb.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
